i2s_playback_tx: RTL and testbench
==================================

Name: i2s_playback_tx

Overview:
- Playback-side I2S transmitter. It is the sink for the sample sources (sine, player, filtered paths).
- Accepts one stereo sample pair per frame through a valid/ready handshake and buffers it one deep.
- Generates bclk and pblrc from mclk and serializes the pair MSB-first on pbdat in Philips I2S format for the codec DAC.
- Runs entirely in the mclk domain. Frame rate = mclk / (BCLK_DIV*64), i.e. 256x with the defaults.

Parameters:
- SAMPLE_BITS, 16: sample width, signed, 2..31; left-justified in a 32-bit slot.
- BCLK_DIV, 4: mclk cycles per bclk period; power of two, >=2.
- UNDERRUN_CNT_BITS, 16: width of the saturating underrun counter.

Ports:
- mclk  input  1  master clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- sample_l  input  SAMPLE_BITS  left-channel sample, signed.
- sample_r  input  SAMPLE_BITS  right-channel sample, signed.
- valid  input  1  sample_l/sample_r are valid this cycle.
- ready  output  1  block accepts the pair this cycle (combinational).
- bclk  output  1  I2S bit clock, registered.
- pblrc  output  1  playback LR clock: 0 = left, 1 = right; registered.
- pbdat  output  1  serial playback data, registered.
- frame_start  output  1  one-mclk pulse on the cycle a new frame is loaded.
- underrun  output  1  one-mclk pulse when a frame is loaded with no sample pair held.
- underrun_count  output  UNDERRUN_CNT_BITS  saturating count of underruns.

Behaviour:
- Phase counter cnt, width log2(BCLK_DIV*64), counts 0..BCLK_DIV*64-1 every mclk and wraps. Bit index b = cnt / BCLK_DIV (0..63). Slot position s = b mod 32.
- bclk_next = 1 in the upper half of each BCLK_DIV group. pblrc_next = (b >= 32).
- pbdat_next:
  - s = 0: 0 (the I2S one-bclk delay).
  - s = 1..SAMPLE_BITS: frame word bit [SAMPLE_BITS - s], taken from the left word when b < 32, otherwise the right word.
  - Any other s: 0.
- bclk, pblrc and pbdat are registered from these *_next values, so they lag cnt by exactly one mclk. Consequence: pbdat and pblrc change only on bclk falling edges, and the codec samples on rising edges.
- Holding register hold_l/hold_r plus flag hold_full; frame registers frm_l/frm_r.
- load = (cnt == BCLK_DIV*64-1).
- ready = !rst && (!hold_full || load).
- Handshake: a transfer occurs when valid && ready; hold_* and hold_full are set on that edge. valid while ready is low is ignored; sources hold data until ready.
- At load with hold_full:
  - frm <= hold and frame_start pulses.
  - hold_full clears unless a transfer happens the same cycle, in which case the new pair enters hold and hold_full stays 1 (simultaneous load and accept).
- At load with !hold_full:
  - frm <= 0 (silence), frame_start and underrun both pulse.
  - underrun_count increments and saturates at all-ones.
  - A transfer in that same cycle lands in hold and is played in the next frame.
- Latency: a pair accepted in frame N (before its load) starts on pbdat at output slot s=1 of frame N+1, which is BCLK_DIV+1 mclk after the load edge.
- Reset (any cycle, including mid-frame): cnt=0; bclk=0, pblrc=0, pbdat=0; hold_full=0; frm=0; frame_start=0, underrun=0, underrun_count=0; ready=0 while rst is high. The frame in flight is abandoned.
- The first load after reset release occurs BCLK_DIV*64-1 cycles after the first non-reset cycle. With no valid before then, that load records an underrun.

Decomposition:
- Shared package audio_pkg:
  - sample_t typedef (shortint for 16-bit).
  - SLOT_BITS=32.
  - FRAME_BITS=64.
  - MCLK_PER_FRAME=256.
- Sub-module i2s_clock_gen (parameter BCLK_DIV) owns cnt and produces bit index b, bclk_next, pblrc_next and the load strobe.
- i2s_playback_tx keeps the handshake, the buffers, the serializer mux and the counters.

Test Plan:
- Single frame: reset, then present L=16'h8001, R=16'h7FFE with valid until accepted.
  - Next frame, pblrc low: pbdat bits per bclk = 0, 1000000000000001, then fifteen 0s.
  - pblrc high: 0, 0111111111111110, then fifteen 0s.
  - frame_start pulses once per 256 mclk.
- Backpressure: after reset hold valid high with pairs A, B, C changing on each accept.
  - A is accepted on the first cycle, then ready=0 until the load cycle.
  - B is accepted on the load cycle.
  - Frames play A then B; C waits for the next load.
- Underrun: no valid for 3 frames after reset.
  - pbdat stays 0 and underrun pulses 3 times, coinciding with frame_start.
  - underrun_count=3.
  - valid then resumes: count holds at 3 and audio follows one frame later.
- Saturation: UNDERRUN_CNT_BITS=2 and 5 starved frames -> underrun_count sticks at 3.
- Mid-frame reset: assert rst for 1 cycle at cnt=100 with a pair held.
  - All outputs go to 0 and hold is emptied.
  - The next load, 255 cycles after release, flags an underrun; the held pair is never played.
- Clock ratios: BCLK_DIV=4 gives bclk period 4 mclk and pblrc period 256 mclk, each at 50% duty. BCLK_DIV=2 gives 2 and 128 respectively.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the playback path: sample type and I2S framing constants.
package audio_pkg;

    typedef shortint sample_t;

    localparam int SLOT_BITS      = 32;
    localparam int FRAME_BITS     = 64;
    localparam int MCLK_PER_FRAME = 256;

endpackage

// File: rtl/i2s_playback_tx_if.sv
// Sample-pair handshake between an audio source (master) and the I2S transmitter (slave).
interface i2s_playback_tx_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 16
) ();

    logic [SAMPLE_BITS-1:0] sample_l;
    logic [SAMPLE_BITS-1:0] sample_r;
    logic                   valid;
    logic                   ready;

    modport master (output sample_l, output sample_r, output valid, input ready);
    modport slave  (input sample_l, input sample_r, input valid, output ready);

endinterface

// File: rtl/i2s_clock_gen.sv
// Frame phase counter: derives the bit index, the next bclk/pblrc levels and the frame load strobe.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic       mclk,
    input  logic       rst,
    output logic [5:0] bit_idx,
    output logic       bclk_next,
    output logic       pblrc_next,
    output logic       load
);

    localparam int CNT_W = $clog2(BCLK_DIV * FRAME_BITS);
    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [CNT_W-1:0] cnt;

    // Free-running phase counter; wraps naturally because the frame length is a power of two.
    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_idx    = cnt[CNT_W-1:DIV_W];
    assign bclk_next  = cnt[DIV_W-1];
    assign pblrc_next = bit_idx[5];
    assign load       = (cnt == '1);

endmodule

// File: rtl/i2s_playback_tx.sv
// Playback I2S transmitter: one-deep sample buffer, frame register and Philips-format serializer.
module i2s_playback_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS       = 16,
    parameter int BCLK_DIV          = 4,
    parameter int UNDERRUN_CNT_BITS = 16
) (
    input  logic                         mclk,
    input  logic                         rst,
    i2s_playback_tx_if.slave             smp,
    output logic                         bclk,
    output logic                         pblrc,
    output logic                         pbdat,
    output logic                         frame_start,
    output logic                         underrun,
    output logic [UNDERRUN_CNT_BITS-1:0] underrun_count
);

    logic [5:0]             bit_idx;
    logic                   bclk_next;
    logic                   pblrc_next;
    logic                   load;

    logic [SAMPLE_BITS-1:0] hold_l;
    logic [SAMPLE_BITS-1:0] hold_r;
    logic                   hold_full;
    logic [SAMPLE_BITS-1:0] frm_l;
    logic [SAMPLE_BITS-1:0] frm_r;

    logic                   xfer;
    logic [4:0]             slot_pos;
    logic [4:0]             slot_bit;
    logic [SLOT_BITS-1:0]   slot_word;
    logic                   pbdat_next;

    i2s_clock_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clock_gen (
        .mclk       (mclk),
        .rst        (rst),
        .bit_idx    (bit_idx),
        .bclk_next  (bclk_next),
        .pblrc_next (pblrc_next),
        .load       (load)
    );

    // The load cycle frees the buffer, so a new pair can be taken in the same cycle.
    assign smp.ready   = !rst && (!hold_full || load);
    assign xfer        = smp.valid && smp.ready;
    assign frame_start = load && !rst;
    assign underrun    = load && !rst && !hold_full;

    // Serializer mux: the sample sits left-justified in a 32-bit slot, so slot position s
    // maps to slot bit 32-s (taken mod 32); position 0 is the one-bclk I2S delay.
    always_comb begin
        slot_pos   = bit_idx[4:0];
        slot_bit   = 5'd0 - slot_pos;
        slot_word  = bit_idx[5] ? {frm_r, {(SLOT_BITS-SAMPLE_BITS){1'b0}}}
                                : {frm_l, {(SLOT_BITS-SAMPLE_BITS){1'b0}}};
        pbdat_next = (slot_pos != 5'd0) && slot_word[slot_bit];
    end

    // I2S output registers, one mclk behind the phase counter.
    always_ff @(posedge mclk) begin
        if (rst) begin
            bclk  <= 1'b0;
            pblrc <= 1'b0;
            pbdat <= 1'b0;
        end else begin
            bclk  <= bclk_next;
            pblrc <= pblrc_next;
            pbdat <= pbdat_next;
        end
    end

    // Holding buffer, frame register and saturating underrun counter.
    always_ff @(posedge mclk) begin
        if (rst) begin
            hold_l         <= '0;
            hold_r         <= '0;
            hold_full      <= 1'b0;
            frm_l          <= '0;
            frm_r          <= '0;
            underrun_count <= '0;
        end else begin
            if (xfer) begin
                hold_l    <= smp.sample_l;
                hold_r    <= smp.sample_r;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                if (hold_full) begin
                    frm_l <= hold_l;
                    frm_r <= hold_r;
                end else begin
                    frm_l <= '0;
                    frm_r <= '0;
                    if (underrun_count != '1) begin
                        underrun_count <= underrun_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_playback_tx.sv
// Scoreboard bench for i2s_playback_tx: a frame-level model queues expected frames, a serial
// monitor rebuilds frames from bclk/pblrc/pbdat and compares them against the queue.
module tb_i2s_playback_tx;
    import audio_pkg::*;

    localparam int SB     = 16;
    localparam int FRAME  = MCLK_PER_FRAME;  // BCLK_DIV = 4
    localparam int FRAME2 = 128;             // BCLK_DIV = 2

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    logic        bclk, pblrc, pbdat, frame_start, underrun;
    logic [15:0] underrun_count;
    logic        bclk2, pblrc2, pbdat2, frame_start2, underrun2;
    logic [1:0]  underrun_count2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    i2s_playback_tx_if #(.SAMPLE_BITS(SB)) bus ();
    i2s_playback_tx_if #(.SAMPLE_BITS(SB)) bus2 ();

    i2s_playback_tx #(
        .SAMPLE_BITS(SB), .BCLK_DIV(4), .UNDERRUN_CNT_BITS(16)
    ) dut (
        .mclk(mclk), .rst(rst), .smp(bus),
        .bclk(bclk), .pblrc(pblrc), .pbdat(pbdat),
        .frame_start(frame_start), .underrun(underrun), .underrun_count(underrun_count)
    );

    i2s_playback_tx #(
        .SAMPLE_BITS(SB), .BCLK_DIV(2), .UNDERRUN_CNT_BITS(2)
    ) dut2 (
        .mclk(mclk), .rst(rst), .smp(bus2),
        .bclk(bclk2), .pblrc(pblrc2), .pbdat(pbdat2),
        .frame_start(frame_start2), .underrun(underrun2), .underrun_count(underrun_count2)
    );

    // Master clock.
    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int unsigned     mcnt  = 0;
    int unsigned     m2cnt = 0;
    int unsigned     m_uc  = 0;
    bit              m_full = 1'b0;
    logic [SB-1:0]   m_l = '0, m_r = '0;
    logic [2*SB-1:0] expq[$];

    // Each frame boundary queues the pair that frame will play (or silence on a starved frame).
    always @(posedge mclk) begin : model
        bit ld, acc;
        if (rst) begin
            mcnt = 0; m2cnt = 0; m_uc = 0; m_full = 1'b0;
            expq.delete();
            expq.push_back('0);
        end else begin
            ld  = (mcnt == FRAME - 1);
            acc = bus.valid && (!m_full || ld);
            if (ld) begin
                if (m_full) expq.push_back({m_l, m_r});
                else begin
                    expq.push_back('0);
                    if (m_uc < 65535) m_uc++;
                end
                m_full = 1'b0;
            end
            if (acc) begin
                m_l = bus.sample_l; m_r = bus.sample_r; m_full = 1'b1;
            end
            mcnt  = (mcnt + 1) % FRAME;
            m2cnt = (m2cnt + 1) % FRAME2;
        end
    end

    // ---------------- monitor ----------------
    int unsigned bitcnt = 0;
    logic [63:0] fbits  = '0;
    bit          prev_b = 1'b0;

    // Per-cycle handshake/strobe checks, and frame reassembly on bclk rising edges.
    always @(negedge mclk) begin : monitor
        logic [2*SB-1:0] e;
        logic [63:0]     ef;
        chk("ready", bus.ready, !rst && (!m_full || mcnt == FRAME - 1));
        chk("frame_start", frame_start, !rst && mcnt == FRAME - 1);
        chk("underrun", underrun, !rst && !m_full && mcnt == FRAME - 1);
        chk("underrun_count", underrun_count, m_uc);
        chk("ready2", bus2.ready, !rst);
        chk("pbdat2", pbdat2, 0);
        chk("frame_start2", frame_start2, !rst && m2cnt == FRAME2 - 1);
        chk("underrun2", underrun2, !rst && m2cnt == FRAME2 - 1);
        if (rst) begin
            bitcnt = 0;
            prev_b = 1'b0;
        end else begin
            if (bclk && !prev_b) begin
                chk("pblrc_at_bit", pblrc, (bitcnt % 64) >= 32);
                fbits = {fbits[62:0], pbdat};
                if (bitcnt % 64 == 63) begin
                    chk("frame_queue_nonempty", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        e  = expq.pop_front();
                        ef = {1'b0, e[2*SB-1:SB], {(31-SB){1'b0}}, 1'b0, e[SB-1:0], {(31-SB){1'b0}}};
                        chk("frame_bits", fbits, ef);
                    end
                end
                bitcnt++;
            end
            prev_b = bclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge mclk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.valid = 1'b0;
        repeat (n) step();
        @(negedge mclk);
        chk("rst_bclk", bclk, 0);
        chk("rst_pblrc", pblrc, 0);
        chk("rst_pbdat", pbdat, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_count", underrun_count, 0);
        chk("rst_count2", underrun_count2, 0);
        @(posedge mclk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [SB-1:0] l, input logic [SB-1:0] r, input int maxw,
                        output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        bus.sample_l = l; bus.sample_r = r; bus.valid = 1'b1;
        while (!acc && waited <= maxw) begin
            @(negedge mclk);
            acc = bus.ready;
            @(posedge mclk); #1;
            if (!acc) waited++;
        end
        bus.valid = 1'b0;
        chk("accepted", acc, 1);
    endtask

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return bclk;
            1:       return pblrc;
            2:       return bclk2;
            default: return pblrc2;
        endcase
    endfunction

    task automatic measure(input string name, input int s, input int period);
        logic prev, cur;
        bit   seen, done;
        int   n, hi;
        seen = 1'b0; done = 1'b0; n = 0; hi = 0;
        @(negedge mclk);
        prev = sel_sig(s);
        cur  = prev;
        for (int i = 0; i < 4 * period + 8 && !seen; i++) begin
            @(negedge mclk);
            cur = sel_sig(s);
            if (cur && !prev) seen = 1'b1;
            prev = cur;
        end
        chk({name, "_rise_seen"}, seen, 1);
        if (seen) begin
            for (int i = 0; i < 2 * period + 4 && !done; i++) begin
                if (cur) hi++;
                n++;
                prev = cur;
                @(negedge mclk);
                cur = sel_sig(s);
                if (cur && !prev) done = 1'b1;
            end
            chk({name, "_period"}, n, period);
            chk({name, "_high"}, hi, period / 2);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #1_500_000;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Main sequence of directed and randomized phases.
    initial begin
        int w;
        bus.sample_l = '0; bus.sample_r = '0; bus.valid = 1'b0;
        bus2.sample_l = '0; bus2.sample_r = '0; bus2.valid = 1'b0;

        // Single known frame.
        do_reset(3);
        send(16'h8001, 16'h7FFE, 300, w);
        chk("single_wait", w, 0);
        repeat (3 * FRAME) step();

        // Backpressure with valid held continuously.
        do_reset(2);
        send(SB'($urandom), SB'($urandom), 600, w);
        chk("bp_A_wait", w, 0);
        send(SB'($urandom), SB'($urandom), 600, w);
        chk("bp_B_wait", w, FRAME - 2);
        send(SB'($urandom), SB'($urandom), 600, w);
        chk("bp_C_wait", w, FRAME - 1);
        for (int i = 0; i < 3; i++) send(SB'($urandom), SB'($urandom), 600, w);
        repeat (3 * FRAME) step();

        // Randomized traffic: per frame choose idle, sparse or saturating valid.
        do_reset(2);
        for (int f = 0; f < 20; f++) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < FRAME; c++) begin
                bus.sample_l = SB'($urandom);
                bus.sample_r = SB'($urandom);
                bus.valid    = (mode == 2) || (mode == 1 && $urandom_range(0, 63) == 0);
                step();
            end
        end
        bus.valid = 1'b0;
        repeat (2 * FRAME + 10) step();

        // Starvation: three frames without data, saturation on the narrow counter.
        do_reset(2);
        repeat (266) step();
        @(negedge mclk);
        chk("sat_count2_after2", underrun_count2, 2);
        step();
        repeat (383) step();
        @(negedge mclk);
        chk("sat_count2_after5", underrun_count2, 3);
        step();
        repeat (127) step();
        @(negedge mclk);
        chk("underrun_count_3", underrun_count, 3);
        step();
        for (int i = 0; i < 3; i++) send(SB'($urandom), SB'($urandom), 600, w);
        @(negedge mclk);
        chk("underrun_count_holds", underrun_count, 3);
        step();
        repeat (2 * FRAME + 10) step();

        // Mid-frame reset with a pair held: the pair is dropped and the next load underruns.
        do_reset(2);
        send(16'h1234, 16'hABCD, 300, w);
        repeat (99) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge mclk);
        chk("mid_bclk", bclk, 0);
        chk("mid_pblrc", pblrc, 0);
        chk("mid_pbdat", pbdat, 0);
        chk("mid_ready", bus.ready, 1);
        step();
        repeat (253) step();
        @(negedge mclk);
        chk("mid_no_early_underrun", underrun, 0);
        step();
        @(negedge mclk);
        chk("mid_underrun_at_load", underrun, 1);
        chk("mid_frame_start_at_load", frame_start, 1);
        step();
        repeat (2 * FRAME + 10) step();

        // Clock ratios for both dividers.
        do_reset(2);
        measure("bclk_div4", 0, 4);
        measure("pblrc_div4", 1, FRAME);
        measure("bclk_div2", 2, 2);
        measure("pblrc_div2", 3, FRAME2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
